// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial operand streamer and its word collector.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int SERIAL_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_word_collector.sv
// Reassembles the adder's sum bits (LSB first) into a parallel word and counts beats
// so the streamer knows when the current beat is the MSB beat.
module serial_word_collector
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_ser_vld,
    input  logic             i_ser_sum,
    output logic [WIDTH-1:0] o_word,
    output logic             o_last_beat
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH:0]   w_res_in;

    // Concatenate then drop the LSB so the shift also works for WIDTH == 1.
    assign w_res_in = {i_ser_sum, r_res};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
            r_res <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
            r_res <= '0;
        end else if (i_ser_vld) begin
            r_cnt <= r_cnt + 1'b1;
            r_res <= w_res_in[WIDTH:1];
        end
    end

    assign o_word      = r_res;
    assign o_last_beat = (r_cnt == LAST_CNT);

endmodule

// File: rtl/serial_operand_streamer.sv
// Parallel-to-serial operand front-end and serial-to-parallel result back-end
// wrapped around an external bit-serial adder.
module serial_operand_streamer
    import serial_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    input  logic             i_stall,
    output logic             o_ser_vld,
    output logic             o_ser_a,
    output logic             o_ser_b,
    output logic             o_ser_last,
    input  logic             i_ser_sum,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_sum
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic             w_accept;
    logic             w_cnt_last;
    logic [WIDTH-1:0] w_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        o_in_ready  = 1'b0;
        o_ser_vld   = 1'b0;
        o_ser_last  = 1'b0;
        o_ser_a     = 1'b0;
        o_ser_b     = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_in_ready = 1'b1;
                if (i_in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // ser_a/ser_b follow the held operand LSB, so they stay put on stalls.
                o_ser_a    = r_op_a[0];
                o_ser_b    = r_op_b[0];
                o_ser_vld  = !i_stall;
                o_ser_last = !i_stall && w_cnt_last;
                if (o_ser_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op_a <= '0;
            r_op_b <= '0;
        end else if (w_accept) begin
            r_op_a <= i_in_a;
            r_op_b <= i_in_b;
        end else if (o_ser_vld) begin
            r_op_a <= r_op_a >> 1;
            r_op_b <= r_op_b >> 1;
        end
    end

    serial_word_collector #(
        .WIDTH (WIDTH)
    ) u_collector (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_accept),
        .i_ser_vld   (o_ser_vld),
        .i_ser_sum   (i_ser_sum),
        .o_word      (w_word),
        .o_last_beat (w_cnt_last)
    );

    assign o_out_sum = w_word;

endmodule

// File: doc/serial_operand_streamer.md
Name: serial_operand_streamer

Overview:
- Front-end and back-end for a bit-serial adder.
- Accepts a pair of parallel operands over a valid/ready handshake and drives them LSB-first as a vld/a/b/last bit stream.
- Captures the adder's combinational sum bit each valid beat and reassembles it into a parallel result, presented over a second valid/ready handshake.
- Sits between a parallel producer/consumer and the serial adder.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  operand pair available.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- stall  input  1  when high, inserts a bubble: no serial beat this cycle.
- ser_vld  output  1  serial beat valid.
- ser_a  output  1  current bit of A.
- ser_b  output  1  current bit of B.
- ser_last  output  1  current beat is the MSB beat.
- ser_sum  input  1  adder sum bit, combinational from ser_a/ser_b/carry in the same cycle.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  WIDTH  assembled sum, modulo 2^WIDTH (final carry is not observable and is dropped).

Behaviour:
- States: IDLE, SHIFT, DONE. Registers: op_a/op_b shift registers, res shift register, beat counter of width max(1, $clog2(WIDTH)).
- Reset (async, rst_n low): state=IDLE, all registers 0. in_ready=1 after reset; ser_vld, ser_last, out_valid = 0; ser_a, ser_b = 0; out_sum = 0.
- IDLE:
  - in_ready=1, ser_vld=0.
  - in_valid & in_ready: load op_a=in_a, op_b=in_b, counter=0, res=0; go to SHIFT.
- SHIFT:
  - in_ready=0, out_valid=0.
  - ser_a=op_a[0], ser_b=op_b[0], ser_vld = !stall.
  - ser_last = (counter == WIDTH-1) & !stall. ser_last is never high without ser_vld.
  - Each cycle with ser_vld=1: res shifts right with ser_sum entering at MSB; op_a/op_b shift right; counter++.
  - Beat with ser_last=1: next state DONE.
  - stall=1: all registers hold; ser_a/ser_b keep their current values.
- DONE:
  - out_valid=1, out_sum=res (stable while waiting), in_ready=0, ser_vld=0.
  - out_valid & out_ready: go to IDLE.
  - No bypass path from DONE to a new load; a new accept takes one IDLE cycle.
- Latency with no stalls:
  - Accept at cycle 0.
  - Serial beats at cycles 1..WIDTH.
  - out_valid high from cycle WIDTH+1.
  - Each stall cycle adds one cycle.
- Boundary conditions:
  - WIDTH=1: the single beat carries ser_last=1.
  - in_valid while not in IDLE: ignored; the producer must hold it per valid/ready rules.
  - out_ready asserted before DONE: no effect.
  - Reset mid-SHIFT: immediately returns to IDLE and abandons the word. The adder's carry is cleared only by its own reset or by a last beat, so the system resets both blocks together.

Decomposition:
- Package serial_pkg:
  - state enum type (IDLE/SHIFT/DONE, 2-bit).
  - default width constant SERIAL_WIDTH_DEFAULT = 8.
- One natural sub-module: serial_word_collector, holding the res shift register and beat counter. It takes ser_vld/ser_sum and produces the assembled word plus a last-beat flag.
- FSM and operand shifters stay in the top module.

Test Plan:
- WIDTH=8, no stall, in_a=8'h0F, in_b=8'h01 -> 8 beats with ser_last on the 8th only; out_sum=8'h10; out_valid at cycle 9 after accept.
- Overflow then next word: 8'hFF+8'h01 -> out_sum=8'h00. Then 8'h01+8'h01 -> out_sum=8'h02, proving the last beat cleared the adder carry.
- Stall pattern 1,0,1,1,0… on 8'hA5+8'h5A -> ser_vld=0 and ser_a/ser_b steady on stall cycles; exactly 8 valid beats; out_sum=8'hFF.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_sum stable, in_ready=0. On release -> IDLE and in_ready=1 next cycle.
- Assert rst_n low asynchronously mid-SHIFT (beat 4) -> outputs return to reset values without a clock edge. A following word 8'h03+8'h04 yields 8'h07.
- WIDTH=1: 1'b1+1'b1 -> single beat with ser_vld=ser_last=1; out_sum=1'b0.
